// File: rtl/vend_dispense_ctrl.sv
// rtl/vend_dispense_ctrl.sv - vend dispense controller: price detect, dispenser handshake, change return
//
// Purpose: waits in IDLE for the upstream credit to reach PRICE, then runs a
// req/ack handshake with the product dispenser and pays back change as
// single-unit coin pulses spaced CHANGE_GAP cycles apart.
// Build option: define VEND_REFUND_EN to turn a dispense timeout into a full
// refund of the credit (fault raised during the refund, cleared back in IDLE).
// Without it a timeout parks in a sticky FAULT state until reset.
//
// Ports:
//   clk_i               system clock, rising edge
//   rst_i               synchronous active-high reset
//   total_i[3:0]        accumulated credit, sampled only in IDLE
//   dispense_ack_i      dispenser has released the product (used only in REQ)
//   dispense_req_o      dispense request, held until ack or timeout
//   change_pulse_o      one-cycle pulse per coin unit returned
//   change_remaining_o  change units still to return
//   busy_o              high in every state except IDLE
//   vend_done_o         one-cycle pulse on successful completion
//   fault_o             dispense timeout indicator
module vend_dispense_ctrl #(
    parameter int unsigned PRICE       = 4,
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned CHANGE_GAP  = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] total_i,
    input  logic       dispense_ack_i,
    output logic       dispense_req_o,
    output logic       change_pulse_o,
    output logic [3:0] change_remaining_o,
    output logic       busy_o,
    output logic       vend_done_o,
    output logic       fault_o
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int GW = (CHANGE_GAP > 1) ? $clog2(CHANGE_GAP) : 1;
    localparam logic [3:0]    PRICE_V  = 4'(PRICE);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(CHANGE_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CHG_ON,
        S_CHG_GAP,
        S_DONE,
        S_FAULT
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    chg_q, chg_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          fault_q, fault_d;
    logic          req_q, pulse_q, busy_q, done_q;
`ifdef VEND_REFUND_EN
    logic [3:0]    credit_q, credit_d;
`endif

    always_comb begin
        state_d = state_q;
        chg_d   = chg_q;
        tmo_d   = tmo_q;
        gap_d   = gap_q;
        fault_d = fault_q;
`ifdef VEND_REFUND_EN
        credit_d = credit_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (total_i >= PRICE_V) begin
                    state_d = S_REQ;
                    chg_d   = total_i - PRICE_V;
                    tmo_d   = '0;
`ifdef VEND_REFUND_EN
                    credit_d = total_i;
`endif
                end
            end
            S_REQ: begin
                // Ack is checked first so an ack in the final timeout cycle still completes.
                if (dispense_ack_i) begin
                    state_d = (chg_q != 4'd0) ? S_CHG_ON : S_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    fault_d = 1'b1;
`ifdef VEND_REFUND_EN
                    chg_d   = credit_q;
                    state_d = S_CHG_ON;
`else
                    state_d = S_FAULT;
`endif
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_CHG_ON: begin
                if (chg_q != 4'd0) begin
                    chg_d = chg_q - 4'd1;
                end
                gap_d = '0;
                if (chg_q > 4'd1) begin
                    state_d = S_CHG_GAP;
                end else begin
`ifdef VEND_REFUND_EN
                    // A refund (fault set) skips DONE and reports no vend_done.
                    state_d = fault_q ? S_IDLE : S_DONE;
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_CHG_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_CHG_ON;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
`ifdef VEND_REFUND_EN
        if (state_d == S_IDLE) begin
            fault_d = 1'b0;
        end
`endif
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            chg_q   <= '0;
            tmo_q   <= '0;
            gap_q   <= '0;
            fault_q <= 1'b0;
            req_q   <= 1'b0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef VEND_REFUND_EN
            credit_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            chg_q   <= chg_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
            fault_q <= fault_d;
            req_q   <= (state_d == S_REQ);
            pulse_q <= (state_d == S_CHG_ON);
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
`ifdef VEND_REFUND_EN
            credit_q <= credit_d;
`endif
        end
    end

    assign dispense_req_o     = req_q;
    assign change_pulse_o     = pulse_q;
    assign change_remaining_o = chg_q;
    assign busy_o             = busy_q;
    assign vend_done_o        = done_q;
    assign fault_o            = fault_q;

endmodule
